// File: rtl/kitchen_timer_pkg.sv
// Shared types and helpers for the MM:SS kitchen timer: FSM states, BCD digit
// type and the binary-to-BCD conversion used by the minute/second loads.
package kitchen_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  localparam bcd_t MAX_TENS = 4'd5;
  localparam bcd_t MAX_ONES = 4'd9;

  // Values above 59 saturate so a field can never hold an out-of-range time.
  function automatic bcd_pair_t bin6_to_bcd(input logic [5:0] bin);
    logic [5:0] val;
    bcd_pair_t  res;
    val      = (bin > 6'd59) ? 6'd59 : bin;
    res.tens = bcd_t'(val / 6'd10);
    res.ones = bcd_t'(val % 6'd10);
    return res;
  endfunction

endpackage

// File: rtl/kitchen_timer_core_tick_gen.sv
// Step-rate generator: one-cycle tick every TICK_DIV (or FAST_DIV) enabled
// cycles; the partial count is kept while enable is low.
module timer_tick_gen #(
  parameter int TICK_DIV = 100_000_000,
  parameter int FAST_DIV = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic fast,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;

  assign last = fast ? FAST_LAST : TICK_LAST;

  // Greater-or-equal so switching to the fast rate mid-count cannot overrun.
  assign tick = enable && (cnt >= last);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kitchen_timer_core.sv
// MM:SS kitchen timer: load/run/pause/alarm sequencing and the BCD up/down
// counter chain driving the 4-digit display and the alarm LED.
//
//   state  | meaning
//   IDLE   | stopped, loads accepted, tick counter held at 0
//   RUN    | counting on each tick, loads ignored
//   PAUSED | digits and partial tick count frozen, loads accepted
//   DONE   | alarm (led=1), digits frozen until load or start
module kitchen_timer_core
  import kitchen_timer_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int FAST_DIV = 1_000_000,
  parameter int UP_WRAP  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  num,
  input  logic        get_min,
  input  logic        get_sec,
  input  logic        start,
  input  logic        pause,
  input  logic        fast,
  input  logic        up,
  output logic        running,
  output logic        led,
  output logic [15:0] big_bin
);

  state_t      state;
  logic [15:0] digits;
  logic        tick;
  logic        tick_en;
  logic        tick_clr;
  logic        is_zero;
  logic        is_max;
  logic        load_req;
  logic [15:0] loaded;
  logic [15:0] up_next;
  logic [15:0] dn_next;

  function automatic logic [15:0] count_up(input logic [15:0] d);
    bcd_t m1, m0, s1, s0;
    {m1, m0, s1, s0} = d;
    if (s0 != MAX_ONES) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != MAX_TENS) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != MAX_ONES) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          m1 = (m1 != MAX_TENS) ? m1 + 4'd1 : 4'd0;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  function automatic logic [15:0] count_down(input logic [15:0] d);
    bcd_t m1, m0, s1, s0;
    {m1, m0, s1, s0} = d;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = MAX_ONES;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = MAX_TENS;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = MAX_ONES;
          m1 = (m1 != 4'd0) ? m1 - 4'd1 : MAX_TENS;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  function automatic logic [15:0] apply_load(input logic [15:0] d,
                                             input logic gm,
                                             input logic gs,
                                             input logic [5:0] val);
    logic [15:0] r;
    r = d;
    if (gm) r[15:8] = bin6_to_bcd(val);
    if (gs) r[7:0]  = bin6_to_bcd(val);
    return r;
  endfunction

  assign is_zero  = (digits == 16'h0000);
  assign is_max   = (digits == 16'h5959);
  assign load_req = get_min | get_sec;
  assign loaded   = apply_load(digits, get_min, get_sec, num);
  assign up_next  = count_up(digits);
  assign dn_next  = count_down(digits);

  // Pause wins over a coincident tick, so the tick counter must hold too.
  assign tick_en  = (state == RUN) && !pause;
  assign tick_clr = (state == IDLE) || (state == DONE);

  timer_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .enable (tick_en),
    .fast   (fast),
    .clear  (tick_clr),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      digits  <= 16'h0000;
      running <= 1'b0;
      led     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pause) begin
            state <= PAUSED;
          end else if (start) begin
            if (!up && is_zero) begin
              state <= DONE;
              led   <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
            end
          end else if (load_req) begin
            digits <= loaded;
          end
        end

        RUN: begin
          if (pause) begin
            state   <= PAUSED;
            running <= 1'b0;
          end else if (tick) begin
            if (up ? (is_max && (UP_WRAP == 0)) : is_zero) begin
              state   <= DONE;
              running <= 1'b0;
              led     <= 1'b1;
            end else begin
              digits <= up ? up_next : dn_next;
            end
          end
        end

        PAUSED: begin
          if (!pause) begin
            if (start) begin
              state   <= RUN;
              running <= 1'b1;
            end else if (load_req) begin
              digits <= loaded;
            end
          end
        end

        DONE: begin
          if (start) begin
            if (up || !is_zero) begin
              state   <= RUN;
              running <= 1'b1;
              led     <= 1'b0;
            end
          end else if (load_req) begin
            digits <= loaded;
            state  <= IDLE;
            led    <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
          led     <= 1'b0;
        end
      endcase
    end
  end

  assign big_bin = digits;

endmodule

// File: tb/tb_kitchen_timer_core.sv
// Directed bench for kitchen_timer_core with a cycle-stamped scoreboard;
// two instances differ only in UP_WRAP and share all stimulus.
module tb_kitchen_timer_core;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  num = 6'd0;
  logic        get_min = 1'b0;
  logic        get_sec = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        fast = 1'b0;
  logic        up = 1'b0;

  logic        running_a, led_a;
  logic [15:0] big_bin_a;
  logic        running_w, led_w;
  logic [15:0] big_bin_w;

  kitchen_timer_core #(.TICK_DIV(4), .FAST_DIV(1), .UP_WRAP(0)) dut (
    .clock   (clock),
    .reset   (reset),
    .num     (num),
    .get_min (get_min),
    .get_sec (get_sec),
    .start   (start),
    .pause   (pause),
    .fast    (fast),
    .up      (up),
    .running (running_a),
    .led     (led_a),
    .big_bin (big_bin_a)
  );

  kitchen_timer_core #(.TICK_DIV(4), .FAST_DIV(1), .UP_WRAP(1)) dut_w (
    .clock   (clock),
    .reset   (reset),
    .num     (num),
    .get_min (get_min),
    .get_sec (get_sec),
    .start   (start),
    .pause   (pause),
    .fast    (fast),
    .up      (up),
    .running (running_w),
    .led     (led_w),
    .big_bin (big_bin_w)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          which;
    logic [63:0] tag;
    logic [15:0] bin;
    logic        run;
    logic        led;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // which: 0 = stop-at-59:59 instance, 1 = wrapping instance, 2 = both
  task automatic push_exp(input int d, input int which, input logic [63:0] tag,
                          input logic [15:0] b, input logic r, input logic l);
    exp_t e;
    e.cyc = cyc + d;
    e.tag = tag;
    e.bin = b;
    e.run = r;
    e.led = l;
    if (which == 2) begin
      e.which = 0;
      sb.push_back(e);
      e.which = 1;
      sb.push_back(e);
    end else begin
      e.which = which;
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        logic [15:0] ab;
        logic        ar, al;
        ab = (sb[i].which == 0) ? big_bin_a : big_bin_w;
        ar = (sb[i].which == 0) ? running_a : running_w;
        al = (sb[i].which == 0) ? led_a     : led_w;
        total = total + 1;
        if (ab !== sb[i].bin || ar !== sb[i].run || al !== sb[i].led) begin
          bad = bad + 1;
          $display("FAIL %0s inst%0d cyc%0d: got big_bin=%h running=%b led=%b, want big_bin=%h running=%b led=%b",
                   sb[i].tag, sb[i].which, cyc, ab, ar, al,
                   sb[i].bin, sb[i].run, sb[i].led);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    reset = 1'b1;
    wait_cyc(2);
    push_exp(1, 2, "rst", 16'h0000, 1'b0, 1'b0);
    wait_cyc(1);
    reset = 1'b0;

    // load 01:07 and count down at the normal rate
    num = 6'd7; get_sec = 1'b1;
    wait_cyc(1);
    get_sec = 1'b0; num = 6'd1; get_min = 1'b1;
    wait_cyc(1);
    get_min = 1'b0;
    push_exp(1, 2, "load", 16'h0107, 1'b0, 1'b0);
    wait_cyc(1);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    push_exp(3, 2, "pre_tick", 16'h0107, 1'b1, 1'b0);
    push_exp(4, 2, "dn_tick", 16'h0106, 1'b1, 1'b0);
    wait_cyc(4);

    // reset while running
    reset = 1'b1;
    push_exp(1, 2, "rst_run", 16'h0000, 1'b0, 1'b0);
    wait_cyc(1);
    reset = 1'b0;

    // 00:02 down to alarm, then start keeps DONE, then load clears it
    num = 6'd0; get_min = 1'b1;
    wait_cyc(1);
    get_min = 1'b0; num = 6'd2; get_sec = 1'b1;
    wait_cyc(1);
    get_sec = 1'b0; start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    push_exp(4,  2, "dn1", 16'h0001, 1'b1, 1'b0);
    push_exp(8,  2, "dn0", 16'h0000, 1'b1, 1'b0);
    push_exp(11, 2, "dn0hold", 16'h0000, 1'b1, 1'b0);
    push_exp(12, 2, "alarm", 16'h0000, 1'b0, 1'b1);
    wait_cyc(12);
    start = 1'b1;
    push_exp(1, 2, "done_st", 16'h0000, 1'b0, 1'b1);
    wait_cyc(1);
    start = 1'b0; num = 6'd5; get_sec = 1'b1;
    push_exp(1, 2, "done_ld", 16'h0005, 1'b0, 1'b0);
    wait_cyc(1);
    get_sec = 1'b0;

    // clamp of 63 to 59, then 59:58 counting up to the terminal value
    num = 6'd63; get_min = 1'b1;
    push_exp(1, 2, "clamp", 16'h5905, 1'b0, 1'b0);
    wait_cyc(1);
    get_min = 1'b0; num = 6'd58; get_sec = 1'b1;
    push_exp(1, 2, "ld5958", 16'h5958, 1'b0, 1'b0);
    wait_cyc(1);
    get_sec = 1'b0; up = 1'b1; start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    push_exp(4, 2, "up5959", 16'h5959, 1'b1, 1'b0);
    push_exp(8, 0, "up_stop", 16'h5959, 1'b0, 1'b1);
    push_exp(8, 1, "up_wrap", 16'h0000, 1'b1, 1'b0);
    wait_cyc(8);

    // reset while in DONE (and running, for the wrapping instance)
    reset = 1'b1;
    push_exp(1, 2, "rst_done", 16'h0000, 1'b0, 1'b0);
    wait_cyc(1);
    reset = 1'b0; up = 1'b0;

    // 01:00 down with a 10-cycle pause after two counted cycles
    num = 6'd1; get_min = 1'b1;
    wait_cyc(1);
    get_min = 1'b0; start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(2);
    pause = 1'b1;
    push_exp(1,  2, "paused", 16'h0100, 1'b0, 1'b0);
    push_exp(10, 2, "pause10", 16'h0100, 1'b0, 1'b0);
    wait_cyc(10);
    pause = 1'b0; start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    push_exp(1, 2, "resume", 16'h0100, 1'b1, 1'b0);
    push_exp(2, 2, "rem_tick", 16'h0059, 1'b1, 1'b0);
    wait_cyc(2);

    // fast mode: one step per clock
    fast = 1'b1;
    push_exp(1, 2, "fast1", 16'h0058, 1'b1, 1'b0);
    push_exp(2, 2, "fast2", 16'h0057, 1'b1, 1'b0);
    push_exp(3, 2, "fast3", 16'h0056, 1'b1, 1'b0);
    wait_cyc(3);
    fast = 1'b0;

    // start+pause from IDLE lands in PAUSED: a later start runs even at 00:00
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0; start = 1'b1; pause = 1'b1;
    push_exp(1, 2, "st_pause", 16'h0000, 1'b0, 1'b0);
    wait_cyc(1);
    pause = 1'b0;
    push_exp(1, 2, "p_to_run", 16'h0000, 1'b1, 1'b0);
    wait_cyc(1);
    start = 1'b0;
    push_exp(4, 2, "run_done", 16'h0000, 1'b0, 1'b1);
    num = 6'd9; get_sec = 1'b1;
    wait_cyc(2);
    get_sec = 1'b0;
    wait_cyc(2);

    // IDLE at 00:00 counting down goes straight to DONE
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0; start = 1'b1;
    push_exp(1, 2, "idle_dn", 16'h0000, 1'b0, 1'b1);
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(3);

    if (sb.size() != 0) begin
      $display("FAIL leftover: got %0d unchecked expectations, want 0", sb.size());
      total = total + sb.size();
      bad = bad + sb.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kitchen_timer_core.md
Name: kitchen_timer_core

Overview:
Parametrised next-generation MM:SS kitchen timer. Loads minutes and seconds from a 6-bit binary input and counts up or down in BCD at a 1 Hz rate, or at a faster rate in fast mode. Has explicit IDLE/RUN/PAUSED/DONE states, configurable terminal behaviour when counting up, and an internal tick generator. Drives the 4-digit display path through big_bin and the alarm LED.

Parameters:
TICK_DIV, 100_000_000, clock cycles per count step in normal mode (>=1)
FAST_DIV, 1_000_000, clock cycles per count step while fast=1 (>=1, <=TICK_DIV)
UP_WRAP, 0, 1: count-up wraps 59:59 -> 00:00 and keeps running; 0: count-up stops at 59:59 and raises alarm

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high; clears everything
num  input  6  binary value for minutes or seconds; values >59 clamp to 59
get_min  input  1  level; load num into minute digits (IDLE/PAUSED/DONE only)
get_sec  input  1  level; load num into second digits (IDLE/PAUSED/DONE only)
start  input  1  level; begin/resume counting
pause  input  1  level; suspend counting
fast  input  1  selects FAST_DIV rate
up  input  1  1 = count up, 0 = count down; sampled on every tick
running  output  1  high in RUN only
led  output  1  alarm; high in DONE only
big_bin  output  16  {min_1,min_0,sec_1,sec_0}, 4-bit BCD digits

Behaviour:
- Reset (sync): state=IDLE, all digits 0, tick counter 0, led=0, running=0, big_bin=16'h0000. Applies mid-count and mid-alarm.
- Tick generator: counter increments in RUN only. When counter >= (fast ? FAST_DIV : TICK_DIV)-1, tick=1 for one cycle and counter clears, so a fast toggle never overruns. Counter clears on entry to RUN. Counter holds in PAUSED.
- State priority per cycle: reset > pause > start > get_min/get_sec.
- IDLE: get_min/get_sec load clamp(num) as tens=num/10, ones=num%10. Both asserted in the same cycle load both fields. start -> RUN, except down mode with 00:00 -> DONE directly (led=1 next cycle).
- RUN: loads ignored. pause -> PAUSED. On tick:
  - up=1: sec_0, sec_1, min_0, min_1 increment with carry at 9/5/9/5. At 59:59: if UP_WRAP, go to 00:00 and stay in RUN; otherwise hold 59:59 and go to DONE.
  - up=0: borrow chain 0->9/0->5. At 00:00 the tick produces DONE; digits stay 00:00 (no underflow to 59:59).
- PAUSED: digits and tick counter frozen. Loads allowed. start with pause=0 -> RUN; the count continues from the remaining partial tick count.
- DONE: led=1, digits frozen. A load (get_min/get_sec) or start clears led. A load performs the load and goes to IDLE. start -> RUN, or stays DONE if down and 00:00. pause has no effect.
- Outputs are registered and change one cycle after the causing input or tick. Latency start->first count = DIV cycles.
- Digits are always valid BCD; invalid states are never reachable.

Decomposition:
- Package kitchen_timer_pkg: state enum (IDLE, RUN, PAUSED, DONE), 4-bit BCD digit typedef, constants MAX_TENS=5 and MAX_ONES=9, function bin6_to_bcd (clamp to 59 plus tens/ones split).
- One sub-module, timer_tick_gen (parameters TICK_DIV and FAST_DIV; inputs enable, fast, clear; output tick). The FSM and BCD counter chain stay in kitchen_timer_core.

Test Plan:
- TICK_DIV=4, FAST_DIV=1: reset, get_sec with num=7, get_min with num=1, up=0, start -> big_bin=16'h0107, then 16'h0106 after 4 clocks. running=1, led=0.
- Load 00:02, down, start -> after 8 clocks 16'h0000, next tick led=1 and running=0. Then get_sec with num=5 -> led=0, IDLE, 16'h0005.
- Load 59:58, up, UP_WRAP=0 -> 16'h5959 then DONE with led=1. With UP_WRAP=1 -> 16'h0000, still running.
- Load 01:00, down, start, pause for 10 cycles mid-count -> digits frozen. Release pause with start=1 -> 00:59 arrives after the remaining partial tick.
- num=63 on get_min -> min digits 5,9. fast=1 while running -> one decrement per clock. start and pause in the same cycle from IDLE -> PAUSED.
- reset asserted in DONE and in RUN -> next cycle big_bin=0, led=0, running=0, state IDLE.
